// File: rtl/decoder_3to8_led.sv
// -----------------------------------------------------------------------------
// decoder_3to8_led
//
// Registered 3-to-8 line decoder with active-low outputs, modelled on the
// 74x138, driving an 8-LED bank at board top level.
//
// Ports:
//   clk     in   1  system clock, rising-edge active
//   rst     in   1  asynchronous, active-high reset (forces all LEDs off)
//   enable  in   3  {G1, G2A_n, G2B_n}; decoding only when exactly 3'b100
//   switch  in   3  binary select code 0..7
//   led     out  8  registered, active-low; bit k low = LED k selected
// -----------------------------------------------------------------------------
module decoder_3to8_led (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] enable,
  input  logic [2:0] switch,
  output logic [7:0] led
);

  // G1 high with both active-low group enables asserted.
  localparam logic [2:0] ENABLE_CODE = 3'b100;
  localparam logic [7:0] LED_ALL_OFF = 8'hFF;

  logic [7:0] led_next_s;
  logic [7:0] led_r;

  // Active-low one-hot: every bit high except the selected one.
  function automatic logic [7:0] decode_low(input logic [2:0] sel);
    logic [7:0] onehot;
    onehot = 8'h01 << sel;
    return ~onehot;
  endfunction

  // Next LED pattern from the current enable group and select code.
  always_comb begin
    led_next_s = LED_ALL_OFF;
    if (enable == ENABLE_CODE) begin
      led_next_s = decode_low(switch);
    end else begin
      led_next_s = LED_ALL_OFF;
    end
  end

  // Output register; reset drives all LEDs off without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r <= LED_ALL_OFF;
    end else begin
      led_r <= led_next_s;
    end
  end

  assign led = led_r;

endmodule

// File: tb/tb_decoder_3to8_led.sv
module tb_decoder_3to8_led;

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [7:0] exp_led;

  decoder_3to8_led dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led)
  );

  // Clock can be held idle to show reset acts without edges.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference behaviour: LED k is lit (low) only when the 74x138 is enabled.
  function automatic logic [7:0] model_led(input logic [2:0] en, input logic [2:0] sw);
    if (en == 3'd4) return 8'(255 - (1 << sw));
    return 8'd255;
  endfunction

  // Expected output register, reset asynchronously like the board pins demand.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_led = 8'hFF;
    else     exp_led = model_led(enable, switch);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL model_cmp t=%0t: led=%h expected=%h (rst=%b en=%b sw=%0d)",
                 $time, led, exp_led, rst, enable, switch);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t: led=%h expected=%h", name, $time, act, req);
    end
  endtask

  // Inputs change 2 time units after the falling edge, well clear of sampling.
  task automatic drive(input logic r, input logic [2:0] en, input logic [2:0] sw);
    @(negedge clk);
    #2;
    rst    = r;
    enable = en;
    switch = sw;
  endtask

  logic [7:0] sweep_exp [8];
  logic [2:0] dis_codes [7];

  initial begin
    sweep_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    dis_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    clk_run = 1'b0;
    rst     = 1'b0;
    enable  = 3'b000;
    switch  = 3'd0;

    // Reset with the clock idle takes effect immediately.
    #2 rst = 1'b1;
    #1 check("reset_idle", led, 8'hFF);

    check_en = 1'b1;
    clk_run  = 1'b1;
    enable   = 3'b100;
    switch   = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", led, 8'hFF);
    end

    // Full decode sweep, one edge of latency each.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'b100, 3'(i));
      #1 check("sweep_pre_edge", led, (i == 0) ? 8'hFF : sweep_exp[i-1]);
      @(posedge clk); #1;
      check("sweep", led, sweep_exp[i]);
    end

    // Every non-enabling code leaves all LEDs off.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, dis_codes[i], 3'd5);
      @(posedge clk); #1;
      check("disable", led, 8'hFF);
    end
    drive(1'b0, 3'b100, 3'd5);
    @(posedge clk); #1;
    check("reenable", led, 8'hDF);

    // Input change between edges has no effect until the next edge.
    drive(1'b0, 3'b100, 3'd2);
    @(posedge clk); #1;
    check("timing_a", led, 8'hFB);
    drive(1'b0, 3'b100, 3'd6);
    #1 check("timing_hold", led, 8'hFB);
    @(posedge clk); #1;
    check("timing_b", led, 8'hBF);

    // Asynchronous reset mid-operation.
    drive(1'b0, 3'b100, 3'd7);
    @(posedge clk); #1;
    check("pre_async", led, 8'h7F);
    drive(1'b1, 3'b100, 3'd7);
    #1 check("async_rst", led, 8'hFF);
    drive(1'b0, 3'b100, 3'd1);
    #1 check("rst_release_hold", led, 8'hFF);
    @(posedge clk); #1;
    check("rst_release", led, 8'hFD);

    // Random regression, checked every cycle by the compare process.
    for (int i = 0; i < 60; i++) begin
      logic       r;
      logic [2:0] en;
      r  = ($urandom_range(0, 4) == 0);
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      drive(r, en, 3'($urandom_range(0, 7)));
    end
    drive(1'b0, 3'b100, 3'd4);
    @(posedge clk); #1;
    check("final", led, 8'hEF);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
